// File: rtl/test_signal_gen.sv
// Multi-channel programmable square-wave generator: each channel toggles sig_o every hp[i] enabled cycles.
// Optional feature: define TSG_SYNC_EN to add sync_i, a global phase-align strobe.
module test_signal_gen #(
  parameter int CHANNELS   = 12,
  parameter int DIV_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
`ifdef TSG_SYNC_EN
  input  logic                  sync_i,
`endif
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DIV_WIDTH-1:0]  wr_data_i,
  input  logic [CHANNELS-1:0]   en_i,
  output logic [CHANNELS-1:0]   sig_o,
  output logic [CHANNELS-1:0]   sig_n_o,
  output logic                  wr_err_o
);

  localparam logic [DIV_WIDTH-1:0]  ONE    = DIV_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CH_LIM = (ADDR_WIDTH+1)'(CHANNELS);

  logic [DIV_WIDTH-1:0] hp_q  [CHANNELS];
  logic [DIV_WIDTH-1:0] hp_d  [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_q [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  sig_q;
  logic [CHANNELS-1:0]  sig_d;
  logic                 wr_err_q;
  logic                 wr_err_d;
  logic [CHANNELS-1:0]  wr_hit;
  logic [CHANNELS-1:0]  term;
  logic                 addr_ok;
  logic                 sync_w;

`ifdef TSG_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  assign addr_ok = ({1'b0, wr_addr_i} < CH_LIM);

  always_comb begin
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    sig_d    = sig_q;
    wr_hit   = '0;
    term     = '0;
    wr_err_d = wr_en_i && !addr_ok;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en_i && addr_ok && (wr_addr_i == ADDR_WIDTH'(i));
      term[i]   = (hp_q[i] != '0) && (cnt_q[i] == hp_q[i] - ONE);

      if (wr_hit[i]) begin
        hp_d[i] = wr_data_i;
      end

      // A write restarts the count and wins over a coincident terminal count.
      if (sync_w || wr_hit[i] || !en_i[i] || (hp_q[i] == '0) || term[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      // Sync and disable force low; a non-zero write holds the current level.
      if (sync_w || !en_i[i] || (wr_hit[i] && (wr_data_i == '0)) ||
          (!wr_hit[i] && (hp_q[i] == '0))) begin
        sig_d[i] = 1'b0;
      end else if (!wr_hit[i] && term[i]) begin
        sig_d[i] = ~sig_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hp_q     <= '{default: '0};
      cnt_q    <= '{default: '0};
      sig_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign sig_o    = sig_q;
  assign sig_n_o  = ~sig_q;
  assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_test_signal_gen.sv
// Directed bench for test_signal_gen: reset, period, collision, error, stop, enable-gating and sync cases.
module tb_test_signal_gen;
  localparam int CH = 12;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CH-1:0] en;
  logic [CH-1:0] sig;
  logic [CH-1:0] sig_n;
  logic          wr_err;
`ifdef TSG_SYNC_EN
  logic          sync;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CH-1:0] en;
    logic [CH-1:0] sig;
    logic          err;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  test_signal_gen #(.CHANNELS(CH), .DIV_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
`ifdef TSG_SYNC_EN
    .sync_i   (sync),
`endif
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .en_i     (en),
    .sig_o    (sig),
    .sig_n_o  (sig_n),
    .wr_err_o (wr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [CH-1:0] e_sig, input logic e_err);
    logic [CH-1:0] inv;
    inv = ~e_sig;
    chk({name, ":sig"}, {20'd0, sig}, {20'd0, e_sig});
    chk({name, ":sig_n"}, {20'd0, sig_n}, {20'd0, inv});
    chk({name, ":err"}, {31'd0, wr_err}, {31'd0, e_err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected level k edges after a write/restart of a channel with half-period h.
  function automatic logic expbit(input int k, input int h);
    return (k >= 0) && (((k / h) % 2) == 1);
  endfunction

  function automatic vec_t mk(input logic we, input int addr, input int data,
                              input logic [CH-1:0] e, input logic [CH-1:0] s, input logic r);
    vec_t v;
    v.we = we; v.addr = AW'(addr); v.data = DW'(data); v.en = e; v.sig = s; v.err = r;
    return v;
  endfunction

  initial begin
    logic [CH-1:0] e;

    tbl.push_back(mk(1,  2, 5, 12'hFFF, 12'h000, 0));
    tbl.push_back(mk(1,  7, 3, 12'hFFF, 12'h000, 0));
    tbl.push_back(mk(1,  5, 2, 12'hFFF, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h0A0, 0));
    tbl.push_back(mk(1,  2, 3, 12'hFFF, 12'h0A0, 0)); // collision: cnt[2]==4
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h080, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h024, 0));
    tbl.push_back(mk(1,  5, 0, 12'hFFF, 12'h004, 0)); // stop channel 5
    tbl.push_back(mk(1, 13, 7, 12'hFFF, 12'h084, 1)); // out of range
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h080, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h000, 0)); // en[7] low for 10 cycles
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h004, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h004, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h004, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h004, 0));
    tbl.push_back(mk(0,  0, 0, 12'hF7F, 12'h004, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h004, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h000, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h080, 0));
    tbl.push_back(mk(0,  0, 0, 12'hFFF, 12'h080, 0));

    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; en = '0;
`ifdef TSG_SYNC_EN
    sync = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2 check_out("reset_async", 12'h000, 1'b0);
    tick();
    tick();
    check_out("reset_held", 12'h000, 1'b0);

    rst_n = 1'b1;
    en = '1;
    for (int n = 0; n < 100; n++) begin
      tick();
      check_out("post_reset_idle", 12'h000, 1'b0);
    end

    for (int n = 0; n < 2010; n++) begin
      wr_en = (n < 3);
      wr_addr = (n == 0) ? AW'(0) : (n == 1) ? AW'(3) : AW'(11);
      wr_data = (n == 0) ? DW'(1) : (n == 1) ? DW'(4) : DW'(1000);
      tick();
      e = '0;
      e[0]  = expbit(n, 1);
      e[3]  = expbit(n - 1, 4);
      e[11] = expbit(n - 2, 1000);
      check_out("period", e, 1'b0);
    end
    wr_en = 1'b0;

    #2 rst_n = 1'b0;
    #1 check_out("midop_reset_async", 12'h000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      check_out("post_midop_reset_stopped", 12'h000, 1'b0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      wr_en   = tbl[i].we;
      wr_addr = tbl[i].addr;
      wr_data = tbl[i].data;
      en      = tbl[i].en;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].sig, tbl[i].err);
    end
    wr_en = 1'b0;

`ifdef TSG_SYNC_EN
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = DW'(3);
    tick();
    wr_en = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = AW'(4); wr_data = DW'(3);
    tick();
    wr_addr = AW'(6);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    wr_en = 1'b0;
    check_out("sync_edge", 12'h000, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = expbit(k, 3) ? 12'h0D6 : 12'h000;
      check_out("sync_phase", e, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
